// File: rtl/latch_seq_pkg.sv
// latch_seq_pkg
//   Shared types and constants for the latch sequencing controller.
//   - state_t        : controller FSM state encoding
//   - DEF_*          : default data width and phase lengths
//   - max3()         : largest of three phase lengths (sizes the phase counter)
package latch_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    GATE  = 3'd2,
    HOLD  = 3'd3,
    CLEAR = 3'd4
  } state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_GATE_CYC  = 2;
  localparam int DEF_HOLD_CYC  = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/latch_seq_ctrl_if.sv
// latch_seq_ctrl_if
//   Groups the upstream handshake and the latch-bank drive signals.
//   Upstream side : in_valid, in_data, in_ready, clr_req
//   Latch side    : lat_d, lat_g, lat_clr
//   Status        : busy, done
//   modport slave  - the controller
//   modport master - the upstream agent / observer
interface latch_seq_ctrl_if
  import latch_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             clr_req;
  logic [WIDTH-1:0] lat_d;
  logic             lat_g;
  logic             lat_clr;
  logic             busy;
  logic             done;

  modport slave (
    input  in_valid, in_data, clr_req,
    output in_ready, lat_d, lat_g, lat_clr, busy, done
  );

  modport master (
    output in_valid, in_data, clr_req,
    input  in_ready, lat_d, lat_g, lat_clr, busy, done
  );

endinterface

// File: rtl/phase_cnt.sv
// phase_cnt
//   Loadable down counter that saturates at zero.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this edge (takes priority over counting)
//   load_val   : value loaded on entry to a phase (phase length - 1)
//   zero       : counter is at zero, i.e. the current cycle is the last of its phase
module phase_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/latch_seq_ctrl.sv
// latch_seq_ctrl
//   Sequences writes into a bank of level-sensitive latches: after a word is
//   accepted, lat_d is stable for SETUP_CYC cycles, lat_g is high for GATE_CYC
//   cycles, and lat_d is held HOLD_CYC more cycles before done pulses.
//   A clear request drives one CLEAR cycle (lat_clr=1, lat_d=0); if it arrives
//   mid-write it is remembered and runs straight after the write finishes.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : latch_seq_ctrl_if.slave (handshake, latch drive, status)
module latch_seq_ctrl
  import latch_seq_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int GATE_CYC  = DEF_GATE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  latch_seq_ctrl_if.slave  bus
);

  localparam int MAX_PHASE = max3(SETUP_CYC, GATE_CYC, HOLD_CYC);
  localparam int CNT_W     = $clog2(MAX_PHASE) + 1;

  // A zero-length phase would make the latch timing meaningless.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_phase_chk
      localparam int LEN = (gi == 0) ? SETUP_CYC : ((gi == 1) ? GATE_CYC : HOLD_CYC);
      if (LEN < 1) begin : g_bad_len
        $error("latch_seq_ctrl: every phase length must be at least 1");
      end
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] lat_d_reg, lat_d_next;
  logic             lat_g_reg;
  logic             lat_clr_reg;
  logic             done_reg;
  logic             clr_pend_reg, clr_pend_next;
  logic             in_ready;
  logic             accept;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;

  assign in_ready = (state_reg == IDLE) && !bus.clr_req && !clr_pend_reg;
  assign accept   = bus.in_valid && in_ready;

  // Phase counter: reloaded on every state change with (length - 1); the
  // zero flag marks the final cycle of the current phase.
  phase_cnt #(
    .CNT_W (CNT_W)
  ) u_phase_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state, counter load, pending clear and data path
  always_comb begin
    state_next    = state_reg;
    clr_pend_next = clr_pend_reg;
    lat_d_next    = lat_d_reg;
    cnt_load_val  = '0;

    unique case (state_reg)
      IDLE: begin
        // A clear (fresh or pending) always beats a write.
        if (bus.clr_req || clr_pend_reg) begin
          state_next = CLEAR;
        end else if (accept) begin
          state_next = SETUP;
        end
      end
      SETUP: if (cnt_zero) state_next = GATE;
      GATE:  if (cnt_zero) state_next = HOLD;
      HOLD:  if (cnt_zero) state_next = IDLE;
      CLEAR: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    cnt_load = (state_next != state_reg);
    unique case (state_next)
      SETUP:   cnt_load_val = CNT_W'(SETUP_CYC - 1);
      GATE:    cnt_load_val = CNT_W'(GATE_CYC - 1);
      HOLD:    cnt_load_val = CNT_W'(HOLD_CYC - 1);
      default: cnt_load_val = '0;
    endcase

    // Clears requested during a write are merged into one pending flag,
    // released when CLEAR is entered. Requests during CLEAR are absorbed.
    if (state_next == CLEAR) begin
      clr_pend_next = 1'b0;
    end else if (bus.clr_req && (state_reg inside {SETUP, GATE, HOLD})) begin
      clr_pend_next = 1'b1;
    end

    if (state_next == CLEAR) begin
      lat_d_next = '0;
    end else if (accept) begin
      lat_d_next = bus.in_data;
    end
  end

  // Registered outputs and pending flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_d_reg    <= '0;
      lat_g_reg    <= 1'b0;
      lat_clr_reg  <= 1'b0;
      done_reg     <= 1'b0;
      clr_pend_reg <= 1'b0;
    end else begin
      lat_d_reg    <= lat_d_next;
      lat_g_reg    <= (state_next == GATE);
      lat_clr_reg  <= (state_next == CLEAR);
      done_reg     <= (state_reg == HOLD) && (state_next == IDLE);
      clr_pend_reg <= clr_pend_next;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.lat_d    = lat_d_reg;
  assign bus.lat_g    = lat_g_reg;
  assign bus.lat_clr  = lat_clr_reg;
  assign bus.busy     = (state_reg != IDLE);
  assign bus.done     = done_reg;

endmodule

// File: doc/latch_seq_ctrl.md
LATCH_SEQ_CTRL -- requirements
Module: latch_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: data width of the latch bank being driven.
REQ-002 Parameter SETUP_CYC, default 1: cycles lat_d is stable before lat_g rises.
REQ-003 Parameter GATE_CYC, default 2: cycles lat_g is high.
REQ-004 Parameter HOLD_CYC, default 1: cycles lat_d is held after lat_g falls.
REQ-005 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port in_valid, input, 1: upstream word available.
REQ-008 Port in_data, input, WIDTH: upstream word.
REQ-009 Port in_ready, output, 1: block can accept a word this cycle.
REQ-010 Port clr_req, input, 1: request to clear the latch bank.
REQ-011 Port lat_d, output, WIDTH: data to the latch d inputs.
REQ-012 Port lat_g, output, 1: latch gate (transparent while high).
REQ-013 Port lat_clr, output, 1: latch clear.
REQ-014 Port busy, output, 1: high in any state other than IDLE.
REQ-015 Port done, output, 1: one-cycle pulse when a write sequence completes.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, GATE, HOLD and CLEAR.
REQ-017 in_ready SHALL equal (state==IDLE) && !clr_req && !clr_pend; it is combinational from registered state.
REQ-018 Accept SHALL occur on an edge with in_valid && in_ready: in_data is registered into lat_d and the FSM enters SETUP.
REQ-019 SETUP SHALL last SETUP_CYC cycles, then GATE for GATE_CYC cycles, then HOLD for HOLD_CYC cycles, then IDLE.
REQ-020 lat_g SHALL be registered and high exactly during GATE cycles.
REQ-021 lat_d SHALL not change from accept until the next accept or CLEAR.
REQ-022 done SHALL be high for exactly the first IDLE cycle after HOLD; in_ready may be high in that same cycle.
REQ-023 With default parameters and accept at edge 0: SETUP is cycle 1, GATE is cycles 2-3, HOLD is cycle 4, and done is cycle 5.
REQ-024 clr_req in IDLE SHALL move the FSM to CLEAR for one cycle with lat_clr=1 and lat_d=0, then return to IDLE.
REQ-025 When clr_req and in_valid are both high in IDLE, clear SHALL win and no accept occurs.
REQ-026 clr_req while busy SHALL set clr_pend; the write sequence completes first, and CLEAR is entered in the cycle done is high.
REQ-027 clr_pend SHALL be released on CLEAR entry; repeated clr_req while pending SHALL merge into one CLEAR.
REQ-028 in_valid while busy SHALL be ignored (no accept, no data capture).
REQ-029 Phase counting SHALL use a down counter of width $clog2(max phase)+1, loaded on every state entry; no wrap beyond zero.
REQ-030 Each of SETUP_CYC, GATE_CYC and HOLD_CYC SHALL be at least 1, enforced by an elaboration-time check.

Reset
REQ-031 rst_n low SHALL asynchronously force state=IDLE, lat_d=0, lat_g=0, lat_clr=0, done=0, clr_pend=0 and counter=0.
REQ-032 Reset mid-GATE SHALL drop lat_g immediately, without waiting for a clock edge.
REQ-033 in_ready SHALL be high in the first cycle after rst_n deasserts (when clr_req is low).

Structure
REQ-034 Package latch_seq_pkg SHALL hold the state enum typedef and the default phase-length constants.
REQ-035 Sub-module phase_cnt SHALL implement the loadable down counter with a zero flag; the FSM instantiates it once.

Verification
REQ-036 Write 8'hA5 with defaults -> lat_d=A5 from cycle 1, lat_g=1 in cycles 2-3, done=1 in cycle 5, busy=1 in cycles 1-4.
REQ-037 clr_req and in_valid (8'h3C) pulsed together in IDLE -> lat_clr=1 for one cycle, lat_d=00, no accept, no done.
REQ-038 clr_req pulsed in GATE after writing 8'hFF -> sequence finishes, done and CLEAR entry in the same cycle, then lat_clr=1 for one cycle, then lat_d=00.
REQ-039 rst_n dropped during GATE -> lat_g=0 immediately, all outputs 0, in_ready=1 in the first cycle after release.
REQ-040 Back-to-back in_valid with 8'h01, 8'h02 -> second word accepted only in the done cycle, with no lat_g overlap between words.
REQ-041 SETUP_CYC=3, GATE_CYC=1, HOLD_CYC=2 -> lat_g high only in cycle 4, done in cycle 7.
